hls_run_controller: RTL and testbench
=====================================

# hls_run_controller

Sequencer that drives one Bambu-generated accelerator through a complete run with no software in the loop. It accepts a command, streams input words into the accelerator's memory through its slave RAM port, and pulses start. It then counts cycles until done under a watchdog, streams result words back out, and reports pass/timeout status with the cycle count. It sits between the host-side stream fabric and the accelerator's `start_port`/`done_port`/`S_*` slave port. It replaces the behavioural start/done sequencing with synthesizable logic.

## Interface
Parameters:
- ADDR_W, 14: accelerator slave address width (byte address)
- DATA_W, 16: slave data width; word stride = DATA_W/8 bytes
- CNT_W, 32: cycle counter width
- TIMEOUT, 200000000: RUN-phase watchdog limit in cycles, must be < 2^CNT_W

Ports:
- clock  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-low
- cmd_valid / cmd_ready  in/out  1  command handshake; cmd_ready=1 only in IDLE
- cmd_in_base, cmd_out_base  in  ADDR_W  byte base addresses for load / unload
- cmd_in_len, cmd_out_len  in  ADDR_W  word counts; 0 skips the phase
- in_valid / in_ready  in/out  1  input word stream; in_ready=1 only in LOAD with no slave access pending
- in_data  in  DATA_W  input word
- out_valid / out_ready  out/in  1  result word stream
- out_data  out  DATA_W  result word
- status_valid  out  1  one-cycle pulse at end of run
- status_timeout  out  1  1 = watchdog expired
- status_cycles  out  CNT_W  run cycles
- acc_start  out  1  to accelerator `start_port`
- acc_done  in  1  from accelerator `done_port`
- acc_oe, acc_we  out  1  slave channel-0 read/write request
- acc_addr  out  ADDR_W  slave byte address
- acc_wdata  out  DATA_W  slave write data
- acc_size  out  8  constant DATA_W while a request is active, else 0
- acc_rdata  in  DATA_W  slave read data
- acc_rdy  in  1  slave channel-0 DataRdy

## Operation
- States: IDLE → LOAD → START → RUN → UNLOAD → REPORT → IDLE.
- IDLE: latch the command on cmd_valid&cmd_ready, clear the word index, go to LOAD.
- LOAD:
  - Skip to START if in_len=0.
  - Each in_valid&in_ready captures in_data. The controller then holds acc_we=1 at addr=in_base+idx*(DATA_W/8) until acc_rdy.
  - The next word is accepted the cycle after acc_rdy.
  - Leave for START after in_len writes.
- START: acc_start=1 for exactly one cycle; clear the cycle counter to 0.
- RUN:
  - Counter increments every cycle.
  - acc_done=1 → cycles=count+1, timeout=0, go to UNLOAD.
  - count reaching TIMEOUT-1 without done → cycles=TIMEOUT, timeout=1, skip UNLOAD, go to REPORT.
- UNLOAD:
  - Skip if out_len=0.
  - Hold acc_oe=1 until acc_rdy, then capture acc_rdata into out_data and assert out_valid.
  - out_data must stay stable while out_valid&!out_ready.
  - Issue the next read only after the handshake. Leave after out_len words.
- REPORT: status_valid=1 for one cycle. status_timeout/status_cycles stay held until the next command is accepted.
- Address arithmetic wraps modulo 2^ADDR_W.
- Ignored inputs:
  - acc_rdy with no request pending.
  - acc_done outside RUN.
  - in_valid outside LOAD.

## Timing
- Reset (asynchronous assert, synchronous deassert use) drives every output to 0 except cmd_ready. cmd_ready=1 one cycle after reset is released. State = IDLE.
- Reset asserted mid-run aborts immediately; no slave request survives.
- Write latency per word: request visible the cycle after capture, held ≥1 cycle until acc_rdy, plus 1 cycle turnaround.
- Read latency per word: acc_rdy capture → out_valid on the next cycle.
- acc_start is registered and goes high the cycle after entering START.
- acc_done is sampled the cycle after the acc_start pulse at the earliest.
- acc_done in the same cycle as watchdog expiry counts as done (timeout=0).

## Structure
- `hls_ctrl_pkg`: state enum, default widths, WORD_BYTES = DATA_W/8.
- Sub-module `hls_ctrl_watchdog`: clear/enable cycle counter with TIMEOUT compare, outputs count and expired.
- Top level holds the FSM, address/index registers, and the stream registers.

## Test plan
- Load/run/unload: in_len=4 (0x0001..0x0004) at base 0x0100, done after 37 cycles, out_len=4 at 0x0200 → writes to 0x100/0x102/0x104/0x106, one acc_start pulse, status_cycles=37, timeout=0, four out words in order.
- Stalls: acc_rdy delayed 0–3 random cycles, out_ready toggled randomly → no lost or duplicated words, out_data stable while stalled.
- Watchdog: TIMEOUT=100, done never asserted → status_valid with timeout=1, cycles=100, no acc_oe issued.
- Zero lengths: in_len=0, out_len=0, done after 5 → no acc_we/acc_oe, status_cycles=5.
- Wrap: in_base=0x3FFE, in_len=2 → addresses 0x3FFE then 0x0000.
- Reset mid-RUN: reset low at RUN cycle 10 → all outputs 0 asynchronously; after release, a new command completes normally.

Source files
------------

// File: rtl/hls_ctrl_pkg.sv
// Shared types and defaults for the HLS run controller.
// Holds the run-phase state encoding and the slave word stride.
package hls_ctrl_pkg;

  localparam int ADDR_W_DEF  = 14;
  localparam int DATA_W_DEF  = 16;
  localparam int CNT_W_DEF   = 32;
  localparam int TIMEOUT_DEF = 200000000;
  localparam int WORD_BYTES  = DATA_W_DEF / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_UNLOAD,
    S_REPORT
  } state_e;

  function automatic int word_bytes(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/hls_ctrl_watchdog.sv
// RUN-phase cycle counter with clear/enable and TIMEOUT compare.
// expired_o is high while the count sits on the last allowed cycle.
module hls_ctrl_watchdog #(
  parameter int          CNT_W   = 32,
  parameter int unsigned TIMEOUT = 200000000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic [CNT_W-1:0] count_o,
  output logic             expired_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i)
      count_d = '0;
    else if (enable_i)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count_o   = count_q;
  assign expired_o = (count_q == LAST);

endmodule

// File: rtl/hls_run_controller.sv
// Sequences one accelerator run: load, start, run under watchdog,
// unload and report, driving the accelerator slave port directly.
module hls_run_controller
  import hls_ctrl_pkg::*;
#(
  parameter int          ADDR_W  = ADDR_W_DEF,
  parameter int          DATA_W  = DATA_W_DEF,
  parameter int          CNT_W   = CNT_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_in_base,
  input  logic [ADDR_W-1:0] cmd_out_base,
  input  logic [ADDR_W-1:0] cmd_in_len,
  input  logic [ADDR_W-1:0] cmd_out_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              status_valid,
  output logic              status_timeout,
  output logic [CNT_W-1:0]  status_cycles,
  output logic              acc_start,
  input  logic              acc_done,
  output logic              acc_oe,
  output logic              acc_we,
  output logic [ADDR_W-1:0] acc_addr,
  output logic [DATA_W-1:0] acc_wdata,
  output logic [7:0]        acc_size,
  input  logic [DATA_W-1:0] acc_rdata,
  input  logic              acc_rdy
);

  localparam logic [ADDR_W-1:0] STEP =
    ADDR_W'(word_bytes(DATA_W));

  state_e state_q, state_d;

  logic [ADDR_W-1:0] in_base_q, in_base_d;
  logic [ADDR_W-1:0] out_base_q, out_base_d;
  logic [ADDR_W-1:0] in_len_q, in_len_d;
  logic [ADDR_W-1:0] out_len_q, out_len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              oe_q, oe_d;
  logic              ovld_q, ovld_d;
  logic              start_q, start_d;
  logic              st_to_q, st_to_d;
  logic [CNT_W-1:0]  st_cyc_q, st_cyc_d;

  logic              wd_clear;
  logic              wd_en;
  logic [CNT_W-1:0]  wd_count;
  logic              wd_expired;

  hls_ctrl_watchdog #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) u_wd (
    .clk_i    (clock),
    .rst_ni   (reset),
    .clear_i  (wd_clear),
    .enable_i (wd_en),
    .count_o  (wd_count),
    .expired_o(wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    in_base_d  = in_base_q;
    out_base_d = out_base_q;
    in_len_d   = in_len_q;
    out_len_d  = out_len_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    we_d       = we_q;
    oe_d       = oe_q;
    ovld_d     = ovld_q;
    start_d    = 1'b0;
    st_to_d    = st_to_q;
    st_cyc_d   = st_cyc_q;
    wd_clear   = 1'b0;
    wd_en      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          in_base_d  = cmd_in_base;
          out_base_d = cmd_out_base;
          in_len_d   = cmd_in_len;
          out_len_d  = cmd_out_len;
          idx_d      = '0;
          st_to_d    = 1'b0;
          st_cyc_d   = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (we_q) begin
          if (acc_rdy) begin
            we_d  = 1'b0;
            idx_d = idx_q + 1'b1;
          end
        end else if (idx_q == in_len_q) begin
          state_d = S_START;
        end else if (in_valid) begin
          we_d    = 1'b1;
          wdata_d = in_data;
          addr_d  = in_base_q + idx_q * STEP;
        end
      end
      S_START: begin
        start_d  = 1'b1;
        wd_clear = 1'b1;
        state_d  = S_RUN;
      end
      S_RUN: begin
        wd_en = 1'b1;
        // done is not trusted during the start pulse itself
        if (acc_done && !start_q) begin
          st_cyc_d = wd_count + 1'b1;
          st_to_d  = 1'b0;
          idx_d    = '0;
          state_d  = S_UNLOAD;
        end else if (wd_expired) begin
          st_cyc_d = CNT_W'(TIMEOUT);
          st_to_d  = 1'b1;
          state_d  = S_REPORT;
        end
      end
      S_UNLOAD: begin
        if (oe_q) begin
          if (acc_rdy) begin
            oe_d    = 1'b0;
            rdata_d = acc_rdata;
            ovld_d  = 1'b1;
            idx_d   = idx_q + 1'b1;
          end
        end else if (ovld_q) begin
          if (out_ready)
            ovld_d = 1'b0;
        end else if (idx_q == out_len_q) begin
          state_d = S_REPORT;
        end else begin
          oe_d   = 1'b1;
          addr_d = out_base_q + idx_q * STEP;
        end
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      in_base_q  <= '0;
      out_base_q <= '0;
      in_len_q   <= '0;
      out_len_q  <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      we_q       <= 1'b0;
      oe_q       <= 1'b0;
      ovld_q     <= 1'b0;
      start_q    <= 1'b0;
      st_to_q    <= 1'b0;
      st_cyc_q   <= '0;
    end else begin
      state_q    <= state_d;
      in_base_q  <= in_base_d;
      out_base_q <= out_base_d;
      in_len_q   <= in_len_d;
      out_len_q  <= out_len_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      we_q       <= we_d;
      oe_q       <= oe_d;
      ovld_q     <= ovld_d;
      start_q    <= start_d;
      st_to_q    <= st_to_d;
      st_cyc_q   <= st_cyc_d;
    end
  end

  assign cmd_ready      = (state_q == S_IDLE);
  assign in_ready       = (state_q == S_LOAD) && !we_q &&
                          (idx_q != in_len_q);
  assign out_valid      = ovld_q;
  assign out_data       = rdata_q;
  assign status_valid   = (state_q == S_REPORT);
  assign status_timeout = st_to_q;
  assign status_cycles  = st_cyc_q;
  assign acc_start      = start_q;
  assign acc_we         = we_q;
  assign acc_oe         = oe_q;
  assign acc_addr       = addr_q;
  assign acc_wdata      = wdata_q;
  assign acc_size       = (we_q || oe_q) ? 8'(DATA_W) : 8'd0;

endmodule

// File: tb/tb_hls_run_controller.sv
// Scoreboard bench for hls_run_controller with a behavioural
// accelerator slave, done driver and randomised back-pressure.
module tb_hls_run_controller;

  localparam int AW = 14;
  localparam int DW = 16;
  localparam int CW = 32;
  localparam int TO = 100;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_in_base = '0;
  logic [AW-1:0] cmd_out_base = '0;
  logic [AW-1:0] cmd_in_len = '0;
  logic [AW-1:0] cmd_out_len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          status_valid;
  logic          status_timeout;
  logic [CW-1:0] status_cycles;
  logic          acc_start;
  logic          acc_done = 1'b0;
  logic          acc_oe;
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic [7:0]    acc_size;
  logic [DW-1:0] acc_rdata = '0;
  logic          acc_rdy = 1'b0;

  always #5 clock = ~clock;

  hls_run_controller #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .CNT_W  (CW),
    .TIMEOUT(TO)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_in_base   (cmd_in_base),
    .cmd_out_base  (cmd_out_base),
    .cmd_in_len    (cmd_in_len),
    .cmd_out_len   (cmd_out_len),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .status_valid  (status_valid),
    .status_timeout(status_timeout),
    .status_cycles (status_cycles),
    .acc_start     (acc_start),
    .acc_done      (acc_done),
    .acc_oe        (acc_oe),
    .acc_we        (acc_we),
    .acc_addr      (acc_addr),
    .acc_wdata     (acc_wdata),
    .acc_size      (acc_size),
    .acc_rdata     (acc_rdata),
    .acc_rdy       (acc_rdy)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct packed {
    logic          to;
    logic [CW-1:0] cyc;
  } st_t;

  wr_t           exp_wr[$];
  logic [DW-1:0] exp_out[$];
  st_t           exp_st[$];
  logic [DW-1:0] in_q[$];

  logic [DW-1:0] mem [0:(1<<(AW-1))-1];

  int checks = 0;
  int failures = 0;
  bit rnd_rdy = 1'b0;
  bit rnd_out = 1'b0;
  int done_after = 0;
  int we_cnt = 0;
  int oe_cnt = 0;
  int start_cnt = 0;
  int status_cnt = 0;
  int out_cnt = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // accelerator slave: answers each request after 0..3 cycles
  initial begin : slave
    bit busy = 1'b0;
    int wait_n = 0;
    forever begin
      @(posedge clock);
      #1;
      if (!reset) begin
        acc_rdy = 1'b0;
        busy = 1'b0;
      end else if (acc_rdy) begin
        acc_rdy = 1'b0;
        busy = 1'b0;
      end else if (acc_we || acc_oe) begin
        if (!busy) begin
          busy = 1'b1;
          wait_n = rnd_rdy ? int'($urandom_range(0, 3)) : 0;
        end
        if (wait_n == 0) begin
          acc_rdy = 1'b1;
          if (acc_oe) acc_rdata = mem[acc_addr[AW-1:1]];
          if (acc_we) mem[acc_addr[AW-1:1]] = acc_wdata;
        end else begin
          wait_n--;
        end
      end
    end
  end

  initial begin : done_drv
    forever begin
      @(negedge clock);
      if (reset && acc_start && done_after > 0) begin
        repeat (done_after - 1) @(posedge clock);
        #1 acc_done = 1'b1;
        @(posedge clock);
        #1 acc_done = 1'b0;
      end
    end
  end

  initial begin : ready_drv
    forever begin
      @(posedge clock);
      #1 out_ready = rnd_out ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : monitor
    bit            hold_pend = 1'b0;
    logic [DW-1:0] hold_data = '0;
    wr_t           w;
    st_t           s;
    forever begin
      @(negedge clock);
      if (!reset) begin
        hold_pend = 1'b0;
        continue;
      end
      if (acc_start) start_cnt++;
      if (acc_oe) oe_cnt++;
      if (acc_we && acc_rdy) begin
        we_cnt++;
        if (exp_wr.size() == 0) begin
          check("wr_unexpected", 64'(acc_addr), 64'h1_0000);
        end else begin
          w = exp_wr.pop_front();
          check("wr_addr", 64'(acc_addr), 64'(w.addr));
          check("wr_data", 64'(acc_wdata), 64'(w.data));
          check("wr_size", 64'(acc_size), 64'(DW));
        end
      end
      if (hold_pend)
        check("out_hold", 64'({out_valid, out_data}),
              64'({1'b1, hold_data}));
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_out.size() == 0)
          check("out_unexpected", 64'(out_data), 64'h1_0000);
        else
          check("out_data", 64'(out_data), 64'(exp_out.pop_front()));
      end
      if (status_valid) begin
        status_cnt++;
        if (exp_st.size() == 0) begin
          check("st_unexpected", 64'(status_cycles), 64'h1_0000_0000);
        end else begin
          s = exp_st.pop_front();
          check("st_timeout", 64'(status_timeout), 64'(s.to));
          check("st_cycles", 64'(status_cycles), 64'(s.cyc));
        end
      end
    end
  end

  task automatic issue(input logic [AW-1:0] ib, input logic [AW-1:0] il,
                       input logic [AW-1:0] ob, input logic [AW-1:0] ol);
    bit hs = 1'b0;
    int n = 0;
    @(posedge clock);
    #1;
    cmd_valid    = 1'b1;
    cmd_in_base  = ib;
    cmd_in_len   = il;
    cmd_out_base = ob;
    cmd_out_len  = ol;
    while (!hs && n < 100) begin
      @(negedge clock);
      hs = cmd_ready;
      @(posedge clock);
      #1;
      n++;
    end
    cmd_valid = 1'b0;
    check("cmd_accept", 64'(hs), 64'd1);
  endtask

  task automatic send_word(input logic [DW-1:0] d);
    bit hs = 1'b0;
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!hs && n < 100) begin
      @(negedge clock);
      hs = in_ready;
      @(posedge clock);
      #1;
      n++;
    end
    in_valid = 1'b0;
    check("in_accept", 64'(hs), 64'd1);
  endtask

  task automatic run(input logic [AW-1:0] ib, input logic [AW-1:0] il,
                     input logic [AW-1:0] ob, input logic [AW-1:0] ol,
                     input int dn);
    int base;
    done_after = dn;
    base = status_cnt;
    issue(ib, il, ob, ol);
    while (in_q.size() > 0) send_word(in_q.pop_front());
    for (int i = 0; i < 3000 && status_cnt == base; i++)
      @(posedge clock);
    check("status_seen", 64'(status_cnt - base), 64'd1);
    repeat (2) @(posedge clock);
  endtask

  initial begin : stim
    int b;
    for (int i = 0; i < 4; i++) mem[256 + i] = 16'hA000 + 16'(i);

    #12;
    check("rst_outs", 64'({acc_start, acc_we, acc_oe, out_valid,
                           status_valid, status_timeout, in_ready,
                           |status_cycles, |acc_size, |out_data,
                           |acc_addr, |acc_wdata}), 64'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // basic load/run/unload
    in_q = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    exp_wr.push_back('{14'h100, 16'h0001});
    exp_wr.push_back('{14'h102, 16'h0002});
    exp_wr.push_back('{14'h104, 16'h0003});
    exp_wr.push_back('{14'h106, 16'h0004});
    exp_out.push_back(16'hA000);
    exp_out.push_back(16'hA001);
    exp_out.push_back(16'hA002);
    exp_out.push_back(16'hA003);
    exp_st.push_back('{1'b0, 32'd37});
    start_cnt = 0; we_cnt = 0; out_cnt = 0;
    run(14'h0100, 14'd4, 14'h0200, 14'd4, 37);
    check("t1_starts", 64'(start_cnt), 64'd1);
    check("t1_writes", 64'(we_cnt), 64'd4);
    check("t1_reads", 64'(out_cnt), 64'd4);

    // stalls on both slave and output stream, loop-back
    rnd_rdy = 1'b1;
    rnd_out = 1'b1;
    in_q = '{16'h0BAD, 16'h1234, 16'hFFFF, 16'h0000, 16'h5A5A};
    exp_wr.push_back('{14'h400, 16'h0BAD});
    exp_wr.push_back('{14'h402, 16'h1234});
    exp_wr.push_back('{14'h404, 16'hFFFF});
    exp_wr.push_back('{14'h406, 16'h0000});
    exp_wr.push_back('{14'h408, 16'h5A5A});
    exp_out.push_back(16'h0BAD);
    exp_out.push_back(16'h1234);
    exp_out.push_back(16'hFFFF);
    exp_out.push_back(16'h0000);
    exp_out.push_back(16'h5A5A);
    exp_st.push_back('{1'b0, 32'd20});
    out_cnt = 0;
    run(14'h0400, 14'd5, 14'h0400, 14'd5, 20);
    check("t2_reads", 64'(out_cnt), 64'd5);
    rnd_rdy = 1'b0;
    rnd_out = 1'b0;

    // watchdog expiry skips unload
    exp_st.push_back('{1'b1, 32'd100});
    oe_cnt = 0;
    run(14'h0000, 14'd0, 14'h0200, 14'd2, 0);
    check("t3_no_oe", 64'(oe_cnt), 64'd0);

    // done on the expiry cycle wins
    exp_st.push_back('{1'b0, 32'd100});
    run(14'h0000, 14'd0, 14'h0000, 14'd0, 100);

    // zero lengths
    exp_st.push_back('{1'b0, 32'd5});
    we_cnt = 0; oe_cnt = 0;
    run(14'h0123, 14'd0, 14'h0456, 14'd0, 5);
    check("t5_no_we", 64'(we_cnt), 64'd0);
    check("t5_no_oe", 64'(oe_cnt), 64'd0);

    // address wrap
    in_q = '{16'hC0DE, 16'hBEEF};
    exp_wr.push_back('{14'h3FFE, 16'hC0DE});
    exp_wr.push_back('{14'h0000, 16'hBEEF});
    exp_st.push_back('{1'b0, 32'd3});
    run(14'h3FFE, 14'd2, 14'h0000, 14'd0, 3);

    // reset in the middle of RUN
    done_after = 0;
    b = start_cnt;
    issue(14'h0000, 14'd0, 14'h0000, 14'd0);
    for (int i = 0; i < 100 && start_cnt == b; i++) @(negedge clock);
    check("t7_start", 64'(start_cnt - b), 64'd1);
    repeat (10) @(posedge clock);
    #3 reset = 1'b0;
    #1;
    check("t7_rst_outs", 64'({acc_start, acc_we, acc_oe, out_valid,
                              status_valid, status_timeout, in_ready,
                              |status_cycles, |acc_size, |out_data,
                              |acc_addr, |acc_wdata}), 64'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("t7_cmd_ready", 64'(cmd_ready), 64'd1);

    in_q = '{16'h7777};
    exp_wr.push_back('{14'h0010, 16'h7777});
    exp_out.push_back(16'h7777);
    exp_st.push_back('{1'b0, 32'd9});
    run(14'h0010, 14'd1, 14'h0010, 14'd1, 9);

    check("left_wr", 64'(exp_wr.size()), 64'd0);
    check("left_out", 64'(exp_out.size()), 64'd0);
    check("left_st", 64'(exp_st.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : guard
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
